// File: rtl/noc_arb_pkg.sv
// noc_arb_pkg: shared types and helpers for the NoC send-port arbiter.
// Holds the arbiter state enum, default bus widths and the flat-bus slice helper.
package noc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } arb_state_e;

    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 32;

    // Widest single field and widest flattened bus the slice helper handles
    // (up to 8 requesters of up to 64 bits each).
    localparam int SLICE_MAX_W = 64;
    localparam int FLAT_MAX_W  = 8 * SLICE_MAX_W;

    // Extract field 'idx' of width 'w' from a flattened bus (field i at [i*w +: w]).
    // Callers zero-extend the bus to FLAT_MAX_W and keep the low w bits of the result.
    function automatic logic [SLICE_MAX_W-1:0] slice_flat(
        input logic [FLAT_MAX_W-1:0] bus,
        input int unsigned           idx,
        input int unsigned           w
    );
        logic [FLAT_MAX_W-1:0]  shifted;
        logic [SLICE_MAX_W-1:0] keep;
        shifted = bus >> (idx * w);
        if (w >= SLICE_MAX_W) begin
            keep = {SLICE_MAX_W{1'b1}};
        end else begin
            keep = ({{(SLICE_MAX_W-1){1'b0}}, 1'b1} << w) - {{(SLICE_MAX_W-1){1'b0}}, 1'b1};
        end
        return shifted[SLICE_MAX_W-1:0] & keep;
    endfunction

endpackage

// File: rtl/noc_send_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
// Returns the first set bit of 'eligible_i' at or after 'ptr_i', wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

    // Walk candidates starting at the pointer; the first eligible one is kept.
    always_comb begin
        logic [IDX_W-1:0] cand;
        logic             hit;
        found_o = 1'b0;
        idx_o   = {IDX_W{1'b0}};
        cand    = {IDX_W{1'b0}};
        hit     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand    = IDX_W'((32'(ptr_i) + 32'(k)) % 32'(NUM_REQ));
            hit     = eligible_i[cand] & ~found_o;
            idx_o   = hit ? cand : idx_o;
            found_o = found_o | eligible_i[cand];
        end
    end

endmodule

// File: rtl/noc_send_arbiter.sv
// noc_send_arbiter: round-robin arbiter sharing one NoC send port between requesters.
// Captures the winner's address/payload, presents it with valid/ready and returns
// a one-cycle acknowledge. A per-requester mask stops a held PIO level from being
// sent twice. Optional stall abort is enabled with the NOC_ARB_TIMEOUT_EN macro.
module noc_send_arbiter
    import noc_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic                       out_valid,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       err_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1'b1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_e              state_q;
    logic [IDX_W-1:0]        ptr_q;
    logic [NUM_REQ-1:0]      mask_q;
    logic [NUM_REQ-1:0]      mask_d;
    logic                    out_valid_q;
    logic [ADDR_W-1:0]       out_addr_q;
    logic [DATA_W-1:0]       out_data_q;
    logic [NUM_REQ-1:0]      req_ack_q;
    logic                    busy_q;
    logic [IDX_W-1:0]        grant_id_q;
    logic                    err_timeout_q;

    logic [NUM_REQ-1:0]      eligible_s;
    logic                    found_s;
    logic [IDX_W-1:0]        win_idx_s;
    logic [FLAT_MAX_W-1:0]   addr_flat_s;
    logic [FLAT_MAX_W-1:0]   data_flat_s;
    logic [SLICE_MAX_W-1:0]  win_addr_wide_s;
    logic [SLICE_MAX_W-1:0]  win_data_wide_s;
    logic                    unused_slice_bits_s;

`ifdef NOC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]        stall_cnt_q;
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT;
`endif

    assign eligible_s = req_valid & ~mask_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .eligible_i (eligible_s),
        .ptr_i      (ptr_q),
        .found_o    (found_s),
        .idx_o      (win_idx_s)
    );

    assign addr_flat_s     = FLAT_MAX_W'(req_addr);
    assign data_flat_s     = FLAT_MAX_W'(req_data);
    assign win_addr_wide_s = slice_flat(addr_flat_s, 32'(win_idx_s), 32'(ADDR_W));
    assign win_data_wide_s = slice_flat(data_flat_s, 32'(win_idx_s), 32'(DATA_W));
    assign unused_slice_bits_s = ^{win_addr_wide_s, win_data_wide_s};

    // Mask clears wherever the request level is low; the ACK-cycle set of the winner wins.
    always_comb begin
        mask_d = (mask_q & req_valid) |
                 ((state_q == ACK) ? (ONE_HOT0 << grant_id_q) : {NUM_REQ{1'b0}});
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            ptr_q         <= {IDX_W{1'b0}};
            mask_q        <= {NUM_REQ{1'b0}};
            out_valid_q   <= 1'b0;
            out_addr_q    <= {ADDR_W{1'b0}};
            out_data_q    <= {DATA_W{1'b0}};
            req_ack_q     <= {NUM_REQ{1'b0}};
            busy_q        <= 1'b0;
            grant_id_q    <= {IDX_W{1'b0}};
            err_timeout_q <= 1'b0;
`ifdef NOC_ARB_TIMEOUT_EN
            stall_cnt_q   <= {CNT_W{1'b0}};
`endif
        end else begin
            mask_q        <= mask_d;
            req_ack_q     <= {NUM_REQ{1'b0}};
            err_timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found_s) begin
                        out_addr_q  <= win_addr_wide_s[ADDR_W-1:0];
                        out_data_q  <= win_data_wide_s[DATA_W-1:0];
                        grant_id_q  <= win_idx_s;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= GRANT;
`ifdef NOC_ARB_TIMEOUT_EN
                        stall_cnt_q <= {CNT_W{1'b0}};
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                GRANT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        req_ack_q   <= ONE_HOT0 << grant_id_q;
                        state_q     <= ACK;
                    end
`ifdef NOC_ARB_TIMEOUT_EN
                    else if (stall_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        // Stall limit hit: abort, still ack so software is unblocked.
                        out_valid_q   <= 1'b0;
                        req_ack_q     <= ONE_HOT0 << grant_id_q;
                        err_timeout_q <= 1'b1;
                        state_q       <= ACK;
                    end else begin
                        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                    end
`else
                    else begin
                        state_q <= GRANT;
                    end
`endif
                end
                ACK: begin
                    busy_q  <= 1'b0;
                    ptr_q   <= (grant_id_q == LAST_IDX) ? {IDX_W{1'b0}} : grant_id_q + IDX_W'(1);
                    state_q <= IDLE;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ack     = req_ack_q;
    assign out_valid   = out_valid_q;
    assign out_addr    = out_addr_q;
    assign out_data    = out_data_q;
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;
    assign err_timeout = err_timeout_q;

endmodule
